div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_if.sv | 21 ++
 rtl/div_unit.sv | 118 +++++++++++
 tb/tb_div_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response handshake bundle for the 32-bit RV32M divider.
interface div_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [1:0]  div_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  modport master (
    output in_valid, op1, op2, div_op, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, op1, op2, div_op, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU: radix-2 restoring divider on magnitudes, 32 iterations,
// with divide-by-zero and signed-overflow results produced without iterating.
module div_unit (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] quo, rem, dvs, res;
  logic        neg_q, neg_r, want_rem;

  logic        accept, is_signed, div_zero, sgn_ovf, special;
  logic [31:0] mag1, mag2, spec_res;
  logic [32:0] rem_sh, diff;
  logic [31:0] quo_step, rem_step, final_res;

  // Two's-complement magnitude; 0x80000000 maps to unsigned 2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  always_comb begin
    accept    = bus.in_valid && (state == IDLE);
    is_signed = !bus.div_op[0];
    div_zero  = (bus.op2 == 32'd0);
    sgn_ovf   = is_signed && (bus.op1 == 32'h8000_0000) && (bus.op2 == 32'hFFFF_FFFF);
    special   = div_zero || sgn_ovf;
    mag1      = magnitude(bus.op1, is_signed);
    mag2      = magnitude(bus.op2, is_signed);
    spec_res  = 32'd0;
    if (div_zero)
      spec_res = bus.div_op[1] ? bus.op1 : 32'hFFFF_FFFF;
    else
      spec_res = bus.div_op[1] ? 32'd0 : 32'h8000_0000;
  end

  // One restoring step: shift the next dividend bit into the partial remainder,
  // keep the subtraction only when it does not go negative.
  always_comb begin
    rem_sh = {1'b0, rem} << 1;
    rem_sh[0] = quo[31];
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[32]) begin
      rem_step = diff[31:0];
      quo_step = {quo[30:0], 1'b1};
    end else begin
      rem_step = rem_sh[31:0];
      quo_step = {quo[30:0], 1'b0};
    end
    final_res = want_rem ? cond_neg(rem_step, neg_r) : cond_neg(quo_step, neg_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (cnt == 5'd31) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.out       = (state == DONE) ? res : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 5'd0;
      quo      <= 32'd0;
      rem      <= 32'd0;
      dvs      <= 32'd0;
      res      <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (special) begin
              res <= spec_res;
            end else begin
              quo      <= mag1;
              dvs      <= mag2;
              rem      <= 32'd0;
              cnt      <= 5'd0;
              neg_q    <= is_signed && (bus.op1[31] ^ bus.op2[31]);
              neg_r    <= is_signed && bus.op1[31];
              want_rem <= bus.div_op[1];
            end
          end
        end
        CALC: begin
          quo <= quo_step;
          rem <= rem_step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) res <= final_res;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Randomized bench for div_unit against an arithmetic RV32M reference model.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_out = 32'd0;

  div_unit_if bus ();

  div_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // RV32M semantics written directly with SystemVerilog arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00:   return ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return ovf ? 32'd0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 20));
      2:       return 32'd0 - 32'($urandom_range(1, 20));
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      5:       return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  // Output is either the expected result or forced to zero, every cycle.
  always @(negedge clk) begin
    if (bus.out_valid) chk("out_vs_model", bus.out, exp_out);
    else               chk("out_zero_when_idle", bus.out, 32'd0);
  end

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int bp, input logic noise, input logic [31:0] lit,
                     input logic use_lit);
    int n;
    logic [31:0] want, held;
    want = ref_div(op, a, b);
    if (use_lit) chk("model_pin", want, lit);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op1 = a; bus.op2 = b; bus.div_op = op;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("in_ready_timeout", 32'(n), 32'd0);
    exp_out = want;
    @(posedge clk); #1;
    bus.in_valid = noise;
    bus.op1 = $urandom; bus.op2 = $urandom; bus.div_op = 2'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (noise) begin bus.op1 = $urandom; bus.op2 = $urandom; bus.div_op = 2'($urandom); end
    end
    bus.in_valid = 1'b0;
    chk("latency_edges", 32'(n), is_special(op, a, b) ? 32'd0 : 32'd32);
    chk("result", bus.out, use_lit ? lit : want);
    held = bus.out;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_stable", bus.out, held);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("consumed_out_valid", 32'(bus.out_valid), 32'd0);
    chk("consumed_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("no_queued_request", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    bus.in_valid = 1'b0; bus.op1 = 32'd0; bus.op2 = 32'd0;
    bus.div_op = 2'b00; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out", bus.out, 32'd0);
    @(negedge clk); rst = 1'b0;

    run(2'b00, 32'd20, 32'hFFFF_FFFD, 0, 1'b0, 32'hFFFF_FFFA, 1'b1);
    run(2'b10, 32'd20, 32'hFFFF_FFFD, 0, 1'b0, 32'd2, 1'b1);
    run(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 1'b1, 32'h7FFF_FFFF, 1'b1);
    run(2'b11, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, 32'd1, 1'b1);
    run(2'b10, 32'hFFFF_FFEC, 32'd3, 0, 1'b0, 32'hFFFF_FFFE, 1'b1);
    run(2'b01, 32'd7, 32'd0, 0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run(2'b11, 32'd7, 32'd0, 0, 1'b1, 32'd7, 1'b1);
    run(2'b00, 32'hFFFF_FFF9, 32'd0, 0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 32'h8000_0000, 1'b1);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 32'd0, 1'b1);
    run(2'b00, 32'h8000_0000, 32'd1, 0, 1'b0, 32'h8000_0000, 1'b1);
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 32'd0, 1'b1);
    run(2'b00, 32'd20, 32'hFFFF_FFFD, 5, 1'b0, 32'hFFFF_FFFA, 1'b1);

    // Abandon an operation on its 10th CALC cycle.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.div_op = 2'b01; bus.op1 = 32'd1000; bus.op2 = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midcalc_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midcalc_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= bus.out_valid; end
    chk("no_result_after_rst", 32'(seen), 32'd0);
    run(2'b01, 32'd100, 32'd7, 0, 1'b0, 32'd14, 1'b1);

    // Reset wins over a simultaneous request.
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b1; bus.div_op = 2'b01; bus.op1 = 32'd5; bus.op2 = 32'd0;
    @(posedge clk); #1;
    chk("rst_vs_accept_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_vs_accept_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); rst = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_vs_accept_dropped", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 60; i++)
      run(2'($urandom), rnd_opnd(), rnd_opnd(), $urandom_range(0, 2), 1'($urandom), 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
